aes_cipher_core: RTL

AES_CIPHER_CORE -- requirements
Module: aes_cipher_core

---
 rtl/aes_cipher_core.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core: one key-schedule word per cycle, then one round per cycle.
// Optional AES_KEY_REUSE_EN keeps the last expanded key so a repeated key skips expansion.
module aes_cipher_core #(
  parameter int KEY_SIZE = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plaintext,
  input  logic [KEY_SIZE-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ciphertext,
  output logic                busy
);

  localparam int NR = KEY_SIZE / 32 + 6;
  localparam int NK = KEY_SIZE / 32;
  localparam int NW = 4 * (NR + 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  // Bytes are column-major: byte (row r, column c) lives at index 4*c + r.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] mixed;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127 - 8 * i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4 * c + r] = sb[4 * ((c + r) % 4) + r];
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4 * c];
      a1 = sr[4 * c + 1];
      a2 = sr[4 * c + 2];
      a3 = sr[4 * c + 3];
      if (last) mixed[127 - 32 * c -: 32] = {a0, a1, a2, a3};
      else mixed[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return mixed ^ rk;
  endfunction

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, OUT} state_t;

  state_t       state, state_next;
  logic [127:0] aes_state, round_key, round_out;
  logic [3:0]   rnd;
  logic [5:0]   wi;
  logic [2:0]   kmod;
  logic [7:0]   rcon;
  logic [31:0]  temp, new_word;
  logic [31:0]  w [0:NW-1];
  logic         rk_valid, armed, accept, key_hit;

  assign accept = in_valid && in_ready;

`ifdef AES_KEY_REUSE_EN
  logic [KEY_SIZE-1:0] key_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      key_last <= '0;
    else if (accept) key_last <= key;
  end

  assign key_hit = rk_valid && (key == key_last);
`else
  assign key_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = key_hit ? ROUND : KEYEXP;
      KEYEXP:  if (wi == 6'(NW - 1)) state_next = ROUND;
      ROUND:   if (rnd == 4'(NR)) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // armed keeps in_ready low until the first clock edge after reset release.
  always_comb begin
    in_ready  = (state == IDLE) && armed;
    busy      = (state != IDLE);
    out_valid = (state == OUT);
  end

  always_comb begin
    temp = w[wi - 6'd1];
    if (kmod == 3'd0) temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
    else if (NK > 6 && kmod == 3'd4) temp = sub_word(temp);
    new_word  = w[wi - 6'(NK)] ^ temp;
    round_key = {w[{rnd, 2'b00}], w[{rnd, 2'b01}], w[{rnd, 2'b10}], w[{rnd, 2'b11}]};
    round_out = aes_round(aes_state, round_key, rnd == 4'(NR));
  end

  // Round-key store carries no reset; rk_valid says whether its contents can be trusted.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      for (int j = 0; j < NK; j++) w[j] <= key[KEY_SIZE - 1 - 32 * j -: 32];
    end else if (state == KEYEXP) begin
      w[wi] <= new_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aes_state  <= '0;
      rnd        <= '0;
      wi         <= 6'(NK);
      kmod       <= '0;
      rcon       <= 8'h01;
      rk_valid   <= 1'b0;
      armed      <= 1'b0;
      ciphertext <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          aes_state <= plaintext ^ key[KEY_SIZE-1 -: 128];
          rnd       <= 4'd1;
          wi        <= 6'(NK);
          kmod      <= '0;
          rcon      <= 8'h01;
          if (!key_hit) rk_valid <= 1'b0;
        end
        KEYEXP: begin
          wi   <= wi + 6'd1;
          kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= xtime(rcon);
          if (wi == 6'(NW - 1)) rk_valid <= 1'b1;
        end
        ROUND: begin
          aes_state <= round_out;
          rnd       <= rnd + 4'd1;
          if (rnd == 4'(NR) && rk_valid) ciphertext <= round_out;
        end
        default: ;
      endcase
    end
  end

endmodule
